mm_seq_ctrl: RTL

Command sequencer for the 3-entry x 256-bit matrix register file (A=entry 0, B=entry 1, C=entry 2).
- Accepts one command at a time from the core.
- Moves 8 x 32-bit words between memory and A/B/C, launches the MAC unit and writes its result into C, or flushes C.
- Sole driver of the register file's write address, write enable, write data and flush inputs.

---
 rtl/mm_seq_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mm_seq_ctrl.sv
// Command sequencer for the 3-entry x 256-bit matrix register file (A=0, B=1, C=2).
// Optional watchdog on memory/MAC waits: define MM_TIMEOUT_EN.
module mm_seq_ctrl #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 8,
  parameter int TO_CYC = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [31:0]              cmd_addr,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [WORD_W-1:0]        mem_wdata,
  input  logic [WORD_W-1:0]        mem_rdata,
  input  logic                     mem_ack,
  output logic [1:0]               rf_rd,
  output logic                     rf_we,
  output logic                     rf_stc,
  output logic [WORD_W*NWORDS-1:0] rf_wdata,
  input  logic [WORD_W*NWORDS-1:0] rf_c,
  output logic                     mac_start,
  input  logic                     mac_done,
  input  logic [WORD_W*NWORDS-1:0] mac_result,
  output logic                     busy,
  output logic                     err,
  output logic [2:0]               fsm_state
);

  // Handshakes: a command is taken on a rising edge with cmd_valid & cmd_ready;
  // a memory transfer completes on a rising edge with mem_req & mem_ack, and
  // mem_addr/mem_we/mem_wdata hold their values until that edge.

  localparam int MW = WORD_W * NWORDS;
  localparam int KW = $clog2(NWORDS);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDA  = 3'd1;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_STC  = 3'd4;
  localparam logic [2:0] OP_CLRC = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    MSTART = 3'd3,
    MWAIT  = 3'd4,
    WRF    = 3'd5
  } state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_next;
  logic            last_word;
  logic [MW-1:0]   buffer;
  logic [MW-1:0]   buf_load;
  logic [1:0]      target;
  logic [31:0]     base_addr;

`ifdef MM_TIMEOUT_EN
  logic [7:0]      wd;
`endif

  assign k_next    = k + KW'(1);
  assign last_word = (k == KW'(NWORDS - 1));
  assign base_addr = {cmd_addr[31:2], 2'b00};
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // Buffer with the current load word merged in, so the final word can go
  // straight to rf_wdata on the same edge that captures it.
  always_comb begin
    buf_load = buffer;
    buf_load[k*WORD_W +: WORD_W] = mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      buffer    <= '0;
      target    <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rf_rd     <= 2'd0;
      rf_we     <= 1'b0;
      rf_stc    <= 1'b0;
      rf_wdata  <= '0;
      mac_start <= 1'b0;
      err       <= 1'b0;
`ifdef MM_TIMEOUT_EN
      wd        <= '0;
`endif
    end else begin
      rf_we     <= 1'b0;
      rf_rd     <= 2'd0;
      rf_wdata  <= '0;
      rf_stc    <= 1'b0;
      mac_start <= 1'b0;
      err       <= 1'b0;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            k <= '0;
            case (cmd_op)
              OP_LDA, OP_LDB: begin
                state    <= LOAD;
                target   <= (cmd_op == OP_LDB) ? 2'd1 : 2'd0;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= base_addr;
              end
              OP_STC: begin
                state     <= STORE;
                buffer    <= rf_c;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= base_addr;
                mem_wdata <= rf_c[WORD_W-1:0];
              end
              OP_MUL: begin
                state     <= MSTART;
                mac_start <= 1'b1;
              end
              OP_CLRC: rf_stc <= 1'b1;
              OP_NOP:  ;
              default: err <= 1'b1;
            endcase
          end
        end

        LOAD: begin
          if (mem_ack) begin
            buffer <= buf_load;
            k      <= k_next;
            if (last_word) begin
              state    <= WRF;
              mem_req  <= 1'b0;
              mem_addr <= '0;
              rf_we    <= 1'b1;
              rf_rd    <= target;
              rf_wdata <= buf_load;
            end else begin
              mem_addr <= mem_addr + 32'd4;
            end
          end
        end

        STORE: begin
          if (mem_ack) begin
            k <= k_next;
            if (last_word) begin
              state     <= IDLE;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
            end else begin
              mem_addr  <= mem_addr + 32'd4;
              mem_wdata <= buffer[k_next*WORD_W +: WORD_W];
            end
          end
        end

        MSTART: state <= MWAIT;

        MWAIT: begin
          if (mac_done) begin
            state    <= WRF;
            buffer   <= mac_result;
            target   <= 2'd2;
            rf_we    <= 1'b1;
            rf_rd    <= 2'd2;
            rf_wdata <= mac_result;
          end
        end

        WRF: state <= IDLE;

        default: state <= IDLE;
      endcase

`ifdef MM_TIMEOUT_EN
      // Overrides the case above on the abort edge; any ack/done restarts the count.
      if ((((state == LOAD) || (state == STORE)) && !mem_ack) ||
          ((state == MWAIT) && !mac_done)) begin
        if (wd == 8'(TO_CYC - 1)) begin
          state     <= IDLE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          err       <= 1'b1;
          wd        <= '0;
        end else begin
          wd <= wd + 8'd1;
        end
      end else begin
        wd <= '0;
      end
`else
      // Without the watchdog the sequencer waits on mem_ack/mac_done indefinitely.
`endif
    end
  end

endmodule
